stage_screen_sequencer: RTL and testbench
=========================================

# stage_screen_sequencer

Drives one full-screen stage banner (e.g. the 80x40 stage-start image) from trigger to completion. It sits between the game control FSM and the VGA adapter.
- It holds the ROM-based banner drawer in reset until triggered, then releases it and waits out the drawer's fixed start-up latency.
- It forwards exactly one frame of pixels to the VGA adapter with a qualifying `plot` strobe.
- It holds the banner on screen for a programmable time, then pulses `screen_done` so the game FSM can advance.

## Interface
- `PIXELS`, 3200: pixels per banner (80x40).
- `LATENCY`, 2: cycles from `draw_resetn` rising to the first valid drawer pixel (1 delay cycle + 1 ROM cycle).
- `HOLD_CYCLES`, 50_000_000: display time after the last pixel (1 s at 50 MHz).
- `DONE_WIN`, 2: HOLD cycles during which a late `draw_done` is still accepted.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to draw the banner; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE.
- `draw_x`  in  8  drawer x coordinate.
- `draw_y`  in  7  drawer y coordinate.
- `draw_colour`  in  9  drawer colour (ROM q).
- `draw_done`  in  1  drawer frame-complete flag.
- `draw_resetn`  out  1  active-low reset to the drawer.
- `vga_x`  out  8  registered x to the VGA adapter.
- `vga_y`  out  7  registered y to the VGA adapter.
- `vga_colour`  out  9  registered colour to the VGA adapter.
- `plot`  out  1  registered VGA write enable.
- `busy`  out  1  high in any state other than IDLE.
- `screen_done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky flag: drawer never signalled done.

## Operation
- **States:** IDLE, ARM, WAIT, PLOT, HOLD, DONE.
- **IDLE:** `draw_resetn`=0. `start`=1 and `abort`=0 → ARM; `error` is cleared on this transition.
- **ARM:** 1 cycle with `draw_resetn`=0, so the drawer counters and its done flag are guaranteed clear → WAIT.
- **WAIT:** `draw_resetn`=1 for `LATENCY` cycles → PLOT.
- **PLOT:** `draw_resetn`=1 for exactly `PIXELS` cycles. Each cycle captures `draw_x/y/colour` into the `vga_*` registers and sets `plot`=1 on the following cycle.
  - Pixel counter width is `$clog2(PIXELS)`; it ends at `PIXELS-1` → HOLD.
  - Pixel count is governed by the counter only, never by `draw_done`.
- **Done check:** `draw_done` seen high in PLOT or in the first `DONE_WIN` HOLD cycles sets an internal `done_seen` flag. If `done_seen`=0 after HOLD cycle `DONE_WIN`, `error`←1.
- **HOLD:** `draw_resetn`=1 for the first `DONE_WIN` cycles, then 0. This stops the drawer from starting a second frame. After `HOLD_CYCLES` total cycles → DONE.
- **DONE:** `screen_done`=1 for 1 cycle → IDLE.
- **Abort:** `abort`=1 in any non-IDLE state → IDLE next cycle.
  - `plot`=0 from that cycle on; no `screen_done`; `error` unchanged.
  - In IDLE, `abort` wins over a simultaneous `start`.
- `start` outside IDLE is ignored; it is not queued.
- `start` in the DONE cycle is ignored; it is accepted on the next cycle.

## Timing
- **Reset values:** state=IDLE; `draw_resetn`=0; `vga_x`=0, `vga_y`=0, `vga_colour`=0; `plot`=0; `busy`=0; `screen_done`=0; `error`=0; all counters 0.
- **Reset mid-operation:** same values on the next edge; the frame is abandoned.
- **Cycle-level sequence** (`start` sampled at edge T):
  - ARM during T+1.
  - `draw_resetn` rises at T+2.
  - PLOT spans T+2+`LATENCY` … T+1+`LATENCY`+`PIXELS`.
  - `plot` is high T+3+`LATENCY` … T+2+`LATENCY`+`PIXELS`, with exactly `PIXELS` high cycles.
  - `screen_done` is high at T+2+`LATENCY`+`PIXELS`+`HOLD_CYCLES`.
- `vga_*` lag `draw_*` by exactly 1 cycle; `vga_*` keep their last value when `plot`=0.
- The hold counter is sized `$clog2(HOLD_CYCLES+1)` and must not wrap.

## Structure
- **Shared package `vga_pkg`:** state enum; `X_W`=8, `Y_W`=7, `COLOUR_W`=9. Other drawers and the VGA mux reuse these widths.
- **One sub-module `cycle_counter`:** parameter `MAX`; ports `clk`, `reset`, `clear`, `en`, `count`, `last`. Instantiated twice, as the pixel counter and the hold counter.
- The FSM and the output registers live in the top module.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-PLOT → every output at its reset value on the next edge; `plot` never high afterwards.
- **Nominal run:** `PIXELS`=3200, `LATENCY`=2, `HOLD_CYCLES`=10, behavioural drawer model (offset 39,39).
  - 3200 `plot` cycles.
  - First pixel (39,39); last pixel (118,78).
  - `screen_done` exactly once, at T+3214.
- **Missing done:** drawer model never raises `draw_done` → `error`=1 from HOLD cycle 2; `screen_done` still pulses at T+3214.
- **Late done:** `draw_done` rises in HOLD cycle 1 → `error` stays 0.
- **Abort:** `abort` at pixel 1000 → `plot`=0 and `busy`=0 next cycle; no `screen_done`; `draw_resetn`=0.
- **Start/abort collisions:**
  - `start`+`abort` together in IDLE → stays IDLE.
  - `start` in the DONE cycle → ignored.
  - `start` on the next cycle → ARM.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: coordinate/colour widths and the banner sequencer state encoding.
package vga_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_PLOT = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic is_active(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear; o_last flags the terminal count MAX.
module cycle_counter #(
  parameter int MAX = 1,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Count register; saturates at MAX so it can never wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_last) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == W'(MAX));

endmodule

// File: rtl/stage_screen_sequencer.sv
// Sequences one full-screen banner: releases the ROM drawer, forwards one frame of
// pixels to the VGA adapter, holds the image, then pulses o_screen_done.
module stage_screen_sequencer
  import vga_pkg::*;
#(
  parameter int PIXELS      = 3200,
  parameter int LATENCY     = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DONE_WIN    = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [X_W-1:0]      i_draw_x,
  input  logic [Y_W-1:0]      i_draw_y,
  input  logic [COLOUR_W-1:0] i_draw_colour,
  input  logic                i_draw_done,
  output logic                o_draw_resetn,
  output logic [X_W-1:0]      o_vga_x,
  output logic [Y_W-1:0]      o_vga_y,
  output logic [COLOUR_W-1:0] o_vga_colour,
  output logic                o_plot,
  output logic                o_busy,
  output logic                o_screen_done,
  output logic                o_error
);

  localparam int PIX_W  = $clog2(PIXELS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_e r_state, w_step, w_next;

  logic [PIX_W-1:0]  w_pix_count;
  logic [HOLD_W-1:0] w_hold_count;
  logic w_pix_last, w_pix_en, w_pix_clear, w_wait_last;
  logic w_hold_last, w_hold_en, w_hold_clear;
  logic w_accept, w_done_win, w_resetn_next;

  logic                r_done_seen, r_error;
  logic                r_draw_resetn, r_plot, r_busy, r_screen_done;
  logic [X_W-1:0]      r_vga_x;
  logic [Y_W-1:0]      r_vga_y;
  logic [COLOUR_W-1:0] r_vga_colour;

  // The pixel counter also times the WAIT latency; it is cleared again on entry to PLOT.
  assign w_wait_last  = (w_pix_count == PIX_W'(LATENCY - 1));
  assign w_pix_en     = (r_state == ST_WAIT) || (r_state == ST_PLOT);
  assign w_pix_clear  = !w_pix_en || ((r_state == ST_WAIT) && w_wait_last);
  assign w_hold_en    = (r_state == ST_HOLD);
  assign w_hold_clear = (r_state != ST_HOLD);
  assign w_accept     = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_done_win   = (r_state == ST_PLOT) ||
                        ((r_state == ST_HOLD) && (w_hold_count < HOLD_W'(DONE_WIN)));

  cycle_counter #(.MAX(PIXELS - 1), .W(PIX_W)) u_pix_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_pix_clear),
    .i_en    (w_pix_en),
    .o_count (w_pix_count),
    .o_last  (w_pix_last)
  );

  cycle_counter #(.MAX(HOLD_CYCLES - 1), .W(HOLD_W)) u_hold_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_hold_clear),
    .i_en    (w_hold_en),
    .o_count (w_hold_count),
    .o_last  (w_hold_last)
  );

  always_comb begin
    w_step        = r_state;
    w_resetn_next = 1'b0;
    case (r_state)
      ST_IDLE: w_step = w_accept ? ST_ARM : ST_IDLE;
      ST_ARM:  w_step = ST_WAIT;
      ST_WAIT: w_step = w_wait_last ? ST_PLOT : ST_WAIT;
      ST_PLOT: w_step = w_pix_last ? ST_HOLD : ST_PLOT;
      ST_HOLD: w_step = w_hold_last ? ST_DONE : ST_HOLD;
      ST_DONE: w_step = ST_IDLE;
      default: w_step = ST_IDLE;
    endcase
    w_next = i_abort ? ST_IDLE : w_step;
    // Drawer stays enabled only for the first DONE_WIN HOLD cycles so it cannot start a second frame.
    case (w_next)
      ST_WAIT, ST_PLOT: w_resetn_next = 1'b1;
      ST_HOLD: w_resetn_next = (r_state == ST_HOLD) ?
                               (w_hold_count < HOLD_W'(DONE_WIN - 1)) : 1'b1;
      default: w_resetn_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_done_seen <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_done_seen <= 1'b0;
      end else if (w_done_win && i_draw_done) begin
        r_done_seen <= 1'b1;
      end else begin
        r_done_seen <= r_done_seen;
      end
      // The error verdict is taken on the last cycle of the done window, so a done on that cycle still counts.
      if (w_accept) begin
        r_error <= 1'b0;
      end else if ((r_state == ST_HOLD) && !i_abort &&
                   (w_hold_count == HOLD_W'(DONE_WIN - 1)) &&
                   !(r_done_seen || i_draw_done)) begin
        r_error <= 1'b1;
      end else begin
        r_error <= r_error;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_draw_resetn <= 1'b0;
      r_plot        <= 1'b0;
      r_busy        <= 1'b0;
      r_screen_done <= 1'b0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_colour  <= '0;
    end else begin
      r_draw_resetn <= w_resetn_next;
      r_plot        <= (r_state == ST_PLOT) && !i_abort;
      r_busy        <= is_active(w_next);
      r_screen_done <= (w_next == ST_DONE);
      if (r_state == ST_PLOT) begin
        r_vga_x      <= i_draw_x;
        r_vga_y      <= i_draw_y;
        r_vga_colour <= i_draw_colour;
      end else begin
        r_vga_x      <= r_vga_x;
        r_vga_y      <= r_vga_y;
        r_vga_colour <= r_vga_colour;
      end
    end
  end

  assign o_draw_resetn = r_draw_resetn;
  assign o_plot        = r_plot;
  assign o_busy        = r_busy;
  assign o_screen_done = r_screen_done;
  assign o_error       = r_error;
  assign o_vga_x       = r_vga_x;
  assign o_vga_y       = r_vga_y;
  assign o_vga_colour  = r_vga_colour;

endmodule

// File: tb/tb_stage_screen_sequencer.sv
// Directed bench for stage_screen_sequencer with a behavioural banner drawer (offset 39,39).
module tb_stage_screen_sequencer;

  localparam int PIXELS   = 3200;
  localparam int LATENCY  = 2;
  localparam int HOLD     = 10;
  localparam int DONE_WIN = 2;

  logic       i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_abort = 1'b0;
  logic       i_draw_done = 1'b0;
  logic [7:0] i_draw_x = 8'd0;
  logic [6:0] i_draw_y = 7'd0;
  logic [8:0] i_draw_colour = 9'd0;
  logic       o_draw_resetn, o_plot, o_busy, o_screen_done, o_error;
  logic [7:0] o_vga_x;
  logic [6:0] o_vga_y;
  logic [8:0] o_vga_colour;

  int checks = 0, errors = 0;
  int dm_cnt = 0;
  int done_k = 3199;

  // monitor results of the latest run
  int m_plots, m_plots_after, m_plot_first, m_plot_last, m_pix_bad;
  int m_rn_rise, m_rn_fall, m_done_at, m_done_cnt, m_err_at, m_err_before;
  logic [7:0] m_first_x, m_last_x;
  logic [6:0] m_first_y, m_last_y;
  logic [8:0] m_first_c, m_last_c;
  logic [28:0] m_snap;

  always #5 i_clk = ~i_clk;

  stage_screen_sequencer #(
    .PIXELS(PIXELS), .LATENCY(LATENCY), .HOLD_CYCLES(HOLD), .DONE_WIN(DONE_WIN)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_draw_x(i_draw_x), .i_draw_y(i_draw_y), .i_draw_colour(i_draw_colour),
    .i_draw_done(i_draw_done), .o_draw_resetn(o_draw_resetn),
    .o_vga_x(o_vga_x), .o_vga_y(o_vga_y), .o_vga_colour(o_vga_colour),
    .o_plot(o_plot), .o_busy(o_busy), .o_screen_done(o_screen_done), .o_error(o_error)
  );

  // Drawer model: one delay cycle, then pixel k = cnt-1 appears after a ROM cycle.
  always @(posedge i_clk) begin
    if (o_draw_resetn !== 1'b1) begin
      dm_cnt        <= 0;
      i_draw_done   <= 1'b0;
      i_draw_x      <= 8'd0;
      i_draw_y      <= 7'd0;
      i_draw_colour <= 9'd0;
    end else begin
      dm_cnt <= dm_cnt + 1;
      if (dm_cnt >= 1) begin
        i_draw_x      <= 8'(39 + (dm_cnt - 1) % 80);
        i_draw_y      <= 7'(39 + (dm_cnt - 1) / 80);
        i_draw_colour <= 9'((dm_cnt - 1) * 7);
      end
      i_draw_done <= i_draw_done | ((dm_cnt - 1) == done_k);
    end
  end

  function automatic logic [28:0] outs();
    return {o_draw_resetn, o_plot, o_busy, o_screen_done, o_error, o_vga_x, o_vga_y, o_vga_colour};
  endfunction

  // Pulses start (edge T), then samples cycles T+1..T+ncyc on the falling edge.
  task automatic run_frame(input int ncyc, input int abort_at, input int reset_at);
    int ev;
    ev = (abort_at > reset_at) ? abort_at : reset_at;
    m_plots = 0; m_plots_after = 0; m_plot_first = -1; m_plot_last = -1; m_pix_bad = 0;
    m_rn_rise = -1; m_rn_fall = -1; m_done_at = -1; m_done_cnt = 0; m_err_at = -1;
    m_err_before = 0; m_snap = '1;
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) @(negedge i_clk);
      if (o_plot === 1'b1) begin
        if (o_vga_x !== 8'(39 + m_plots % 80) || o_vga_y !== 7'(39 + m_plots / 80) ||
            o_vga_colour !== 9'(m_plots * 7)) m_pix_bad++;
        if (m_plots == 0) begin
          m_first_x = o_vga_x; m_first_y = o_vga_y; m_first_c = o_vga_colour; m_plot_first = n;
        end
        m_last_x = o_vga_x; m_last_y = o_vga_y; m_last_c = o_vga_colour; m_plot_last = n;
        m_plots++;
        if (ev > 0 && n > ev) m_plots_after++;
      end
      if (o_draw_resetn === 1'b1 && m_rn_rise < 0) m_rn_rise = n;
      if (o_draw_resetn === 1'b0 && m_rn_rise > 0 && m_rn_fall < 0) m_rn_fall = n;
      if (o_screen_done === 1'b1) begin m_done_cnt++; m_done_at = n; end
      if (o_error === 1'b1 && m_err_at < 0) m_err_at = n;
      if (n == ev) m_err_before = int'(o_error);
      if (n == ev + 1) m_snap = outs();
      if (n == abort_at) i_abort = 1'b1;
      if (n == abort_at + 1) i_abort = 1'b0;
      if (n == reset_at) i_reset = 1'b1;
      if (n == reset_at + 3) i_reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if (outs() !== 29'd0) begin errors++; $display("FAIL reset_values got %h exp %h", outs(), 29'd0); end
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_nominal();
    done_k = 3199;
    run_frame(3225, -10, -10);
    checks++; if (m_plots !== 3200) begin errors++; $display("FAIL nom_plots got %0d exp 3200", m_plots); end
    checks++; if (m_plot_first !== 5 || m_plot_last !== 3204) begin errors++;
      $display("FAIL nom_plot_window got %0d..%0d exp 5..3204", m_plot_first, m_plot_last); end
    checks++; if ({m_first_x, m_first_y, m_first_c} !== {8'd39, 7'd39, 9'd0}) begin errors++;
      $display("FAIL nom_first_pixel got (%0d,%0d,%0d) exp (39,39,0)", m_first_x, m_first_y, m_first_c); end
    checks++; if ({m_last_x, m_last_y, m_last_c} !== {8'd118, 7'd78, 9'd377}) begin errors++;
      $display("FAIL nom_last_pixel got (%0d,%0d,%0d) exp (118,78,377)", m_last_x, m_last_y, m_last_c); end
    checks++; if (m_pix_bad !== 0) begin errors++; $display("FAIL nom_pixel_stream got %0d bad exp 0", m_pix_bad); end
    checks++; if (m_rn_rise !== 2 || m_rn_fall !== 3206) begin errors++;
      $display("FAIL nom_draw_resetn got rise %0d fall %0d exp 2 3206", m_rn_rise, m_rn_fall); end
    checks++; if (m_done_at !== 3214 || m_done_cnt !== 1) begin errors++;
      $display("FAIL nom_screen_done got at %0d x%0d exp at 3214 x1", m_done_at, m_done_cnt); end
    checks++; if (m_err_at !== -1) begin errors++; $display("FAIL nom_error got rise %0d exp none", m_err_at); end
    checks++; if ({o_busy, o_draw_resetn, o_plot} !== 3'b000) begin errors++;
      $display("FAIL nom_end_idle got %b exp 000", {o_busy, o_draw_resetn, o_plot}); end
  endtask

  task automatic test_missing_done();
    done_k = -5;
    run_frame(3225, -10, -10);
    checks++; if (m_err_at !== 3206) begin errors++; $display("FAIL miss_error_rise got %0d exp 3206", m_err_at); end
    checks++; if (m_done_at !== 3214 || m_done_cnt !== 1) begin errors++;
      $display("FAIL miss_screen_done got at %0d x%0d exp at 3214 x1", m_done_at, m_done_cnt); end
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL miss_error_sticky got %b exp 1", o_error); end
  endtask

  task automatic test_late_done();
    done_k = 3201;
    run_frame(3225, -10, -10);
    checks++; if (m_err_at !== -1) begin errors++; $display("FAIL late_error got rise %0d exp none", m_err_at); end
    checks++; if (m_done_at !== 3214) begin errors++; $display("FAIL late_screen_done got %0d exp 3214", m_done_at); end
  endtask

  task automatic test_abort();
    done_k = 3199;
    run_frame(3225, 1004, -10);
    checks++; if (m_plots !== 1000 || m_plots_after !== 0) begin errors++;
      $display("FAIL abort_plots got %0d after %0d exp 1000 after 0", m_plots, m_plots_after); end
    checks++; if ({m_snap[28:26], m_snap[24]} !== {3'b000, m_err_before[0]}) begin errors++;
      $display("FAIL abort_next_cycle got rn/plot/busy/err %b exp %b", {m_snap[28:26], m_snap[24]}, {3'b000, m_err_before[0]}); end
    checks++; if (m_done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", m_done_cnt); end
  endtask

  task automatic test_reset_mid();
    done_k = 3199;
    run_frame(3300, -10, 2000);
    checks++; if (m_snap !== 29'd0) begin errors++; $display("FAIL midreset_values got %h exp %h", m_snap, 29'd0); end
    checks++; if (m_plots !== 1996 || m_plots_after !== 0) begin errors++;
      $display("FAIL midreset_plots got %0d after %0d exp 1996 after 0", m_plots, m_plots_after); end
    checks++; if (m_done_cnt !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", m_done_cnt); end
  endtask

  task automatic test_collisions();
    @(negedge i_clk); i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk); i_start = 1'b0; i_abort = 1'b0;
    checks++; if ({o_busy, o_draw_resetn} !== 2'b00) begin errors++;
      $display("FAIL start_abort_idle got %b exp 00", {o_busy, o_draw_resetn}); end
    done_k = 3199;
    run_frame(3214, -10, -10);
    checks++; if (o_screen_done !== 1'b1) begin errors++; $display("FAIL done_cycle got %b exp 1", o_screen_done); end
    i_start = 1'b1;
    @(negedge i_clk);
    checks++; if ({o_busy, o_screen_done} !== 2'b00) begin errors++;
      $display("FAIL start_in_done got busy/done %b exp 00", {o_busy, o_screen_done}); end
    @(negedge i_clk);
    i_start = 1'b0;
    checks++; if ({o_busy, o_draw_resetn} !== 2'b10) begin errors++;
      $display("FAIL start_after_done got busy/rn %b exp 10", {o_busy, o_draw_resetn}); end
    @(negedge i_clk);
    checks++; if (o_draw_resetn !== 1'b1) begin errors++; $display("FAIL arm_to_wait got %b exp 1", o_draw_resetn); end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cleanup_abort got %b exp 0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_missing_done();
    test_late_done();
    test_abort();
    test_reset_mid();
    test_collisions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
